rtc_write_sequencer: RTL and testbench
======================================

# rtc_write_sequencer

Parametrised write sequencer for the RTC serial-bus path. On request it emits an ordered list of address/data byte pairs to the bus-timing engine. The engine marks the address phase, data phase and end of each transaction. The block supports a configurable number of time/date fields with a per-field enable mask, clock or timer mode, a built-in power-up init sequence, a start-time snapshot of all operands, and abort. It sits between the main control FSM and the bus-timing engine.

## Interface
- `DW`, 8: byte width of address and data.
- `N_FIELDS`, 6: number of time/date fields, legal range 1..8. Field order is sec, min, hour, day, month, year, then user-defined.
- `TMR_FIELDS`, 3: number of low fields honoured in timer mode; higher mask bits are ignored.
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: reset is asynchronous and active-low; asserting it (low) clears all state.
- `start` in 1: one-cycle request to write the fields; sampled only in IDLE.
- `init_req` in 1: one-cycle request to run the init sequence; sampled only in IDLE; wins over `start` when both are high.
- `abort` in 1: requests early termination; sampled while busy.
- `mode_clk` in 1: 1 = clock registers, 0 = timer registers.
- `fmt_12h` in 1: 1 = 12-hour format.
- `field_mask` in N_FIELDS: 1 = write this field.
- `field_data` in N_FIELDS*DW: field i occupies bits [i*DW +: DW].
- `field_addr` in N_FIELDS*DW: register address of field i in the current mode.
- `dir_ph` in 1: engine requests the address byte.
- `dat_ph` in 1: engine requests the data byte.
- `phase_done` in 1: engine reports that the current transaction is complete.
- `bus_byte` out DW: registered byte presented to the engine.
- `bus_req` out 1: registered transaction request (write enable).
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse at the end of a sequence.
- `aborted` out 1: valid while `done` is high; 1 if the sequence was terminated early.

## Operation
- States: IDLE, INIT, FIELD, XFER, CFG, GAP.
- IDLE:
  - `init_req` → INIT with init index 0.
  - Otherwise, `start` → snapshot `field_*`, `mode_clk` and `fmt_12h`, then go to FIELD at the lowest enabled field.
  - If the effective mask is empty, go straight to XFER.
- Each item is an (addr, data) pair. Per cycle the priority is `dir_ph` > `dat_ph` > `phase_done`:
  - `dir_ph` → `bus_byte` ← addr.
  - `dat_ph` → `bus_byte` ← data.
  - `phase_done` → `bus_req` ← 0 and advance to the next item.
- `bus_byte` holds its value between phases.
- Init ROM, 14 pairs in order: (02,10) (02,00) (10,D2) (10,00) (21,00) (22,00) (23,00) (24,00) (25,00) (26,00) (41,00) (42,00) (43,00) (F0,00).
- FIELD: visits the enabled fields in ascending index order, using the snapshot addr/data.
  - Effective mask = `field_mask` in clock mode.
  - Effective mask = `field_mask[TMR_FIELDS-1:0]` in timer mode.
- XFER: addr is F1 in clock mode, F2 in timer mode; data is 01.
- CFG: addr is 00; data is `{3'b000, fmt_12h, ~mode_clk, 3'b000}`. Concrete values:
  - Clock mode: 10 when 12-hour, 00 when 24-hour.
  - Timer mode: 18 when 12-hour, 08 when 24-hour.
- GAP: the single cycle with `bus_req` low between items. It returns to the next item's state with `bus_req` high.
- Ending a sequence:
  - `phase_done` on the last item (CFG, or the 14th init pair) → IDLE, `busy` ← 0, `done` pulses.
- Abort:
  - `abort` is latched while busy.
  - At the next `phase_done` the sequence ends exactly as above, with `aborted` = 1.
  - The current transaction always completes; it is never cut mid-phase.
- `start` or `init_req` while busy is ignored and not queued.
- Input changes after `start` have no effect on the running sequence.
- Field index width is clog2(N_FIELDS)+1. No arithmetic beyond the index and the priority encoder.

## Timing
- Reset values: `bus_byte` = 0, `bus_req` = 0, `busy` = 0, `done` = 0, `aborted` = 0; state = IDLE.
- `start` or `init_req` high at edge k → `busy` and `bus_req` high from cycle k+1.
- `dir_ph` or `dat_ph` at edge k → `bus_byte` updated at k+1.
- `phase_done` at edge k:
  - `bus_req` is low at k+1.
  - If another item remains, `bus_req` is high again at k+2.
  - On the final item, `busy` = 0 and `done` = 1 at k+1, and `done` = 0 at k+2.
- Reset asserted mid-sequence → all outputs return to reset values immediately, with no `done` pulse.
- Minimum sequence: empty mask = 2 items.

## Test plan
- **Clock write.**
  - Stimulus: N_FIELDS=6, mask 3F, addrs 21..26, data 59,30,12,01,02,17, `fmt_12h`=0.
  - Response: 8 transactions with pairs (21,59)…(26,17), (F1,01), (00,00); one `done` with `aborted`=0.
- **Timer mode with mask 3F.**
  - Response: only fields 0..2 are written, then (F2,01) and (00,08) when `fmt_12h`=0 or (00,18) when `fmt_12h`=1.
- **Init sequence.**
  - Stimulus: `init_req` and `start` in the same cycle.
  - Response: the 14 ROM pairs are emitted in order and no fields are written; `done` pulses once.
- **Sparse mask 05 and empty mask 00.**
  - Mask 05 response: (addr0,d0), (addr2,d2), XFER, CFG.
  - Mask 00 response: XFER then CFG only.
- **Abort.**
  - Stimulus: `abort` pulsed during the `dat_ph` of item 2.
  - Response: item 2 completes; `done` with `aborted`=1 appears one cycle after its `phase_done`; no XFER is issued.
  - Second stimulus: `start` while busy. Response: ignored.
- **Reset and snapshot.**
  - Stimulus: `reset` low during CFG.
  - Response: outputs are 0 the same cycle and there is no `done` pulse.
  - Second stimulus: change `field_data` after `start`. Response: the original values are emitted.

Source files
------------

// File: rtl/rtc_write_sequencer.sv
// RTC write sequencer: turns a write request into an ordered list of
// (address, data) byte pairs for the bus-timing engine. It supports the
// power-up init ROM, masked time/date fields in clock or timer mode, the
// mode/transfer trigger item and the format configuration item.
module rtc_write_sequencer #(
  parameter int DW         = 8,
  parameter int N_FIELDS   = 6,
  parameter int TMR_FIELDS = 3
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_init_req,
  input  logic                   i_abort,
  input  logic                   i_mode_clk,
  input  logic                   i_fmt_12h,
  input  logic [N_FIELDS-1:0]    i_field_mask,
  input  logic [N_FIELDS*DW-1:0] i_field_data,
  input  logic [N_FIELDS*DW-1:0] i_field_addr,
  input  logic                   i_dir_ph,
  input  logic                   i_dat_ph,
  input  logic                   i_phase_done,
  output logic [DW-1:0]          o_bus_byte,
  output logic                   o_bus_req,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_aborted
);

  localparam int         IW        = $clog2(N_FIELDS) + 1;
  localparam logic [3:0] INIT_LAST = 4'd13;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_FIELD, S_XFER, S_CFG, S_GAP} state_t;

  state_t                r_state, r_ret, w_state_nxt, w_ret_nxt;
  logic [3:0]            r_init_idx, w_init_idx_nxt;
  logic [IW-1:0]         r_fidx, w_fidx_nxt;
  logic [N_FIELDS-1:0]   r_pend, w_pend_nxt;
  logic                  r_abort, w_abort_nxt;
  logic [DW-1:0]         r_bus_byte, w_bus_byte_nxt;
  logic                  r_bus_req, w_bus_req_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_aborted, w_aborted_nxt;
  logic                  w_snap;

  logic [N_FIELDS*DW-1:0] r_fa, r_fd;
  logic                   r_mode, r_fmt;

  logic [N_FIELDS-1:0]   w_tmr_keep, w_eff, w_pend_rem;
  logic [DW-1:0]         w_fld_addr, w_fld_data, w_item_addr, w_item_data;
  logic [15:0]           w_rom;
  logic                  w_last, w_abort_any;

  // Init ROM: {addr, data} for each of the 14 power-up register writes.
  function automatic logic [15:0] f_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    f_rom = 16'h0210;
      4'd1:    f_rom = 16'h0200;
      4'd2:    f_rom = 16'h10D2;
      4'd3:    f_rom = 16'h1000;
      4'd4:    f_rom = 16'h2100;
      4'd5:    f_rom = 16'h2200;
      4'd6:    f_rom = 16'h2300;
      4'd7:    f_rom = 16'h2400;
      4'd8:    f_rom = 16'h2500;
      4'd9:    f_rom = 16'h2600;
      4'd10:   f_rom = 16'h4100;
      4'd11:   f_rom = 16'h4200;
      4'd12:   f_rom = 16'h4300;
      4'd13:   f_rom = 16'hF000;
      default: f_rom = 16'h0000;
    endcase
  endfunction

  // Priority encoder: index of the lowest set bit (0 when empty).
  function automatic logic [IW-1:0] f_lowest(input logic [N_FIELDS-1:0] m);
    f_lowest = '0;
    for (int i = N_FIELDS - 1; i >= 0; i--)
      if (m[i]) f_lowest = IW'(i);
  endfunction

  // Effective mask from live inputs, pending-field bookkeeping and field mux.
  always_comb begin
    w_fld_addr = '0;
    w_fld_data = '0;
    for (int i = 0; i < N_FIELDS; i++) begin
      w_tmr_keep[i] = (i < TMR_FIELDS);
      w_pend_rem[i] = r_pend[i] & (r_fidx != IW'(i));
      if (r_fidx == IW'(i)) begin
        w_fld_addr = r_fa[i*DW +: DW];
        w_fld_data = r_fd[i*DW +: DW];
      end
    end
    w_eff = i_mode_clk ? i_field_mask : (i_field_mask & w_tmr_keep);
  end

  // Address/data of the item currently on offer to the engine.
  always_comb begin
    w_rom       = f_rom(r_init_idx);
    w_item_addr = '0;
    w_item_data = '0;
    case (r_state)
      S_INIT: begin
        w_item_addr = DW'(w_rom[15:8]);
        w_item_data = DW'(w_rom[7:0]);
      end
      S_FIELD: begin
        w_item_addr = w_fld_addr;
        w_item_data = w_fld_data;
      end
      S_XFER: begin
        w_item_addr = r_mode ? DW'(8'hF1) : DW'(8'hF2);
        w_item_data = DW'(8'h01);
      end
      S_CFG: begin
        w_item_addr = '0;
        w_item_data = DW'({3'b000, r_fmt, ~r_mode, 3'b000});
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret;
    w_init_idx_nxt = r_init_idx;
    w_fidx_nxt     = r_fidx;
    w_pend_nxt     = r_pend;
    w_abort_nxt    = r_abort;
    w_bus_byte_nxt = r_bus_byte;
    w_bus_req_nxt  = r_bus_req;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_aborted_nxt  = 1'b0;
    w_snap         = 1'b0;
    w_abort_any    = r_abort | i_abort;
    w_last         = (r_state == S_CFG) ||
                     ((r_state == S_INIT) && (r_init_idx == INIT_LAST));
    case (r_state)
      S_IDLE: begin
        if (i_init_req) begin
          w_state_nxt    = S_INIT;
          w_init_idx_nxt = '0;
          w_bus_req_nxt  = 1'b1;
          w_busy_nxt     = 1'b1;
          w_abort_nxt    = 1'b0;
        end else if (i_start) begin
          w_snap        = 1'b1;
          w_bus_req_nxt = 1'b1;
          w_busy_nxt    = 1'b1;
          w_abort_nxt   = 1'b0;
          w_pend_nxt    = w_eff;
          w_fidx_nxt    = f_lowest(w_eff);
          w_state_nxt   = (|w_eff) ? S_FIELD : S_XFER;
        end
      end
      S_GAP: begin
        w_abort_nxt   = w_abort_any;
        w_state_nxt   = r_ret;
        w_bus_req_nxt = 1'b1;
      end
      default: begin
        w_abort_nxt = w_abort_any;
        if (i_dir_ph) begin
          w_bus_byte_nxt = w_item_addr;
        end else if (i_dat_ph) begin
          w_bus_byte_nxt = w_item_data;
        end else if (i_phase_done) begin
          w_bus_req_nxt = 1'b0;
          if (w_last || w_abort_any) begin
            w_state_nxt   = S_IDLE;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b1;
            w_aborted_nxt = w_abort_any;
            w_abort_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_GAP;
            case (r_state)
              S_INIT: begin
                w_ret_nxt      = S_INIT;
                w_init_idx_nxt = r_init_idx + 4'd1;
              end
              S_FIELD: begin
                w_pend_nxt = w_pend_rem;
                w_fidx_nxt = f_lowest(w_pend_rem);
                w_ret_nxt  = (|w_pend_rem) ? S_FIELD : S_XFER;
              end
              default: w_ret_nxt = S_CFG;
            endcase
          end
        end
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_ret      <= S_IDLE;
      r_init_idx <= '0;
      r_fidx     <= '0;
      r_pend     <= '0;
      r_abort    <= 1'b0;
      r_bus_byte <= '0;
      r_bus_req  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ret      <= w_ret_nxt;
      r_init_idx <= w_init_idx_nxt;
      r_fidx     <= w_fidx_nxt;
      r_pend     <= w_pend_nxt;
      r_abort    <= w_abort_nxt;
      r_bus_byte <= w_bus_byte_nxt;
      r_bus_req  <= w_bus_req_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_aborted  <= w_aborted_nxt;
    end
  end

  // Operand snapshot taken when a field write starts.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fa   <= '0;
      r_fd   <= '0;
      r_mode <= 1'b0;
      r_fmt  <= 1'b0;
    end else if (w_snap) begin
      r_fa   <= i_field_addr;
      r_fd   <= i_field_data;
      r_mode <= i_mode_clk;
      r_fmt  <= i_fmt_12h;
    end
  end

  assign o_bus_byte = r_bus_byte;
  assign o_bus_req  = r_bus_req;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_aborted  = r_aborted;

endmodule

// File: tb/tb_rtc_write_sequencer.sv
// Directed bench for rtc_write_sequencer: an engine model services each
// requested item (address phase, data phase, completion) and records what
// the sequencer presented; each scenario task compares against its own
// hand-written expected pairs and status.
module tb_rtc_write_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset, i_start, i_init_req, i_abort, i_mode_clk, i_fmt_12h;
  logic [5:0]  i_field_mask;
  logic [47:0] i_field_data, i_field_addr;
  logic        i_dir_ph, i_dat_ph, i_phase_done;
  logic [7:0]  o_bus_byte;
  logic        o_bus_req, o_busy, o_done, o_aborted;

  int checks = 0;
  int errors = 0;

  logic [7:0]  obs_a [32];
  logic [7:0]  obs_d [32];
  int          obs_n;
  logic        obs_timeout, obs_done, obs_abt, obs_busy_end;
  logic        obs_drop_ok, obs_gap_ok, obs_done_fall;
  logic [1:0]  obs_start;
  logic [7:0]  obs_pre;
  logic [11:0] obs_rst;
  logic        obs_rst_done;

  localparam logic [47:0] ADDRS = {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};
  localparam logic [47:0] DATAS = {8'h17, 8'h02, 8'h01, 8'h12, 8'h30, 8'h59};

  always #5 i_clk = ~i_clk;

  rtc_write_sequencer #(.DW(8), .N_FIELDS(6), .TMR_FIELDS(3)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_init_req(i_init_req),
    .i_abort(i_abort), .i_mode_clk(i_mode_clk), .i_fmt_12h(i_fmt_12h),
    .i_field_mask(i_field_mask), .i_field_data(i_field_data),
    .i_field_addr(i_field_addr), .i_dir_ph(i_dir_ph), .i_dat_ph(i_dat_ph),
    .i_phase_done(i_phase_done), .o_bus_byte(o_bus_byte), .o_bus_req(o_bus_req),
    .o_busy(o_busy), .o_done(o_done), .o_aborted(o_aborted)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1);
  end

  // One-cycle request pulse; records busy/bus_req one cycle later.
  task automatic pulse_req(input logic s, input logic ir);
    i_start = s; i_init_req = ir;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_init_req = 1'b0;
    obs_start = {o_busy, o_bus_req};
  endtask

  // Engine model: services items until done, a timeout, or a planted reset.
  task automatic serve_seq(input int abort_item, input int reset_item);
    int   wcnt;
    logic running;
    obs_n = 0; obs_timeout = 0; obs_done = 0; obs_abt = 0; obs_busy_end = 1;
    obs_drop_ok = 1; obs_gap_ok = 1; obs_done_fall = 1; obs_rst_done = 0;
    for (int i = 0; i < 32; i++) begin obs_a[i] = 'x; obs_d[i] = 'x; end
    running = 1;
    while (running) begin
      wcnt = 0;
      while (!o_bus_req && wcnt < 8) begin @(posedge i_clk); #1; wcnt++; end
      if (!o_bus_req || obs_n >= 24) begin
        obs_timeout = 1; running = 0;
      end else if (obs_n == reset_item) begin
        i_dat_ph = 1; @(posedge i_clk); #1; i_dat_ph = 0;
        obs_pre = o_bus_byte;
        #2 i_reset = 0;
        #1 obs_rst = {o_bus_byte, o_bus_req, o_busy, o_done, o_aborted};
        repeat (3) begin @(posedge i_clk); #1; if (o_done) obs_rst_done = 1; end
        i_reset = 1;
        repeat (3) begin @(posedge i_clk); #1; if (o_done || o_busy) obs_rst_done = 1; end
        running = 0;
      end else begin
        i_dir_ph = 1; @(posedge i_clk); #1; i_dir_ph = 0;
        obs_a[obs_n] = o_bus_byte;
        i_dat_ph = 1; i_abort = (obs_n == abort_item);
        @(posedge i_clk); #1; i_dat_ph = 0; i_abort = 0;
        obs_d[obs_n] = o_bus_byte;
        obs_n++;
        i_phase_done = 1; @(posedge i_clk); #1; i_phase_done = 0;
        if (o_bus_req) obs_drop_ok = 0;
        if (o_done) begin
          obs_done = 1; obs_abt = o_aborted; obs_busy_end = o_busy;
          @(posedge i_clk); #1;
          if (o_done) obs_done_fall = 0;
          running = 0;
        end else begin
          @(posedge i_clk); #1;
          if (!o_bus_req) obs_gap_ok = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    i_reset = 0; i_start = 0; i_init_req = 0; i_abort = 0; i_mode_clk = 1;
    i_fmt_12h = 0; i_field_mask = '0; i_field_data = '0; i_field_addr = '0;
    i_dir_ph = 0; i_dat_ph = 0; i_phase_done = 0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_bus_byte, o_bus_req, o_busy, o_done, o_aborted} !== 12'h000) begin
      errors++;
      $display("FAIL reset_values got %h want 000",
               {o_bus_byte, o_bus_req, o_busy, o_done, o_aborted});
    end
    i_reset = 1;
    @(posedge i_clk); #1;
    checks++;
    if ({o_bus_req, o_busy, o_done} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset got %b want 000", {o_bus_req, o_busy, o_done});
    end
  endtask

  task automatic test_clock_write();
    logic [7:0] ea [8];
    logic [7:0] ed [8];
    ea = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'hF1, 8'h00};
    ed = '{8'h59, 8'h30, 8'h12, 8'h01, 8'h02, 8'h17, 8'h01, 8'h00};
    i_mode_clk = 1; i_fmt_12h = 0; i_field_mask = 6'h3F;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    checks++;
    if (obs_start !== 2'b11) begin
      errors++; $display("FAIL clk_start busy/req got %b want 11", obs_start);
    end
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 8) begin errors++; $display("FAIL clk_count got %0d want 8", obs_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_a[i] !== ea[i] || obs_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL clk_pair%0d got (%h,%h) want (%h,%h)", i, obs_a[i], obs_d[i], ea[i], ed[i]);
      end
    end
    checks++;
    if ({obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall} !== 7'b0100111) begin
      errors++;
      $display("FAIL clk_status got %b want 0100111",
               {obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall});
    end
  endtask

  task automatic test_timer(input logic fmt);
    logic [7:0] ea [5];
    logic [7:0] ed [5];
    ea = '{8'h21, 8'h22, 8'h23, 8'hF2, 8'h00};
    ed = '{8'h59, 8'h30, 8'h12, 8'h01, (fmt ? 8'h18 : 8'h08)};
    i_mode_clk = 0; i_fmt_12h = fmt; i_field_mask = 6'h3F;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 5) begin errors++; $display("FAIL tmr%0d_count got %0d want 5", fmt, obs_n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs_a[i] !== ea[i] || obs_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL tmr%0d_pair%0d got (%h,%h) want (%h,%h)", fmt, i, obs_a[i], obs_d[i], ea[i], ed[i]);
      end
    end
    checks++;
    if ({obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall} !== 7'b0100111) begin
      errors++;
      $display("FAIL tmr%0d_status got %b want 0100111", fmt,
               {obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall});
    end
  endtask

  task automatic test_init();
    logic [7:0] ea [14];
    logic [7:0] ed [14];
    ea = '{8'h02, 8'h02, 8'h10, 8'h10, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26,
           8'h41, 8'h42, 8'h43, 8'hF0};
    ed = '{8'h10, 8'h00, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00};
    i_mode_clk = 1; i_fmt_12h = 0; i_field_mask = 6'h3F;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 1);
    checks++;
    if (obs_start !== 2'b11) begin
      errors++; $display("FAIL init_start busy/req got %b want 11", obs_start);
    end
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 14) begin errors++; $display("FAIL init_count got %0d want 14", obs_n); end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (obs_a[i] !== ea[i] || obs_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL init_pair%0d got (%h,%h) want (%h,%h)", i, obs_a[i], obs_d[i], ea[i], ed[i]);
      end
    end
    checks++;
    if ({obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall} !== 7'b0100111) begin
      errors++;
      $display("FAIL init_status got %b want 0100111",
               {obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall});
    end
  endtask

  task automatic test_sparse_mask();
    logic [7:0] ea [4];
    logic [7:0] ed [4];
    ea = '{8'h21, 8'h23, 8'hF1, 8'h00};
    ed = '{8'h59, 8'h12, 8'h01, 8'h00};
    i_mode_clk = 1; i_fmt_12h = 0; i_field_mask = 6'h05;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 4) begin errors++; $display("FAIL sparse_count got %0d want 4", obs_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_a[i] !== ea[i] || obs_d[i] !== ed[i]) begin
        errors++;
        $display("FAIL sparse_pair%0d got (%h,%h) want (%h,%h)", i, obs_a[i], obs_d[i], ea[i], ed[i]);
      end
    end
    checks++;
    if ({obs_done, obs_abt} !== 2'b10) begin
      errors++; $display("FAIL sparse_done got %b want 10", {obs_done, obs_abt});
    end
  endtask

  task automatic test_back_to_back();
    i_mode_clk = 1; i_fmt_12h = 1; i_field_mask = 6'h00;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    pulse_req(1, 1);
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 2) begin errors++; $display("FAIL empty_count got %0d want 2", obs_n); end
    checks++;
    if ({obs_a[0], obs_d[0], obs_a[1], obs_d[1]} !== 32'hF101_0010) begin
      errors++;
      $display("FAIL empty_pairs got %h want f1010010", {obs_a[0], obs_d[0], obs_a[1], obs_d[1]});
    end
    checks++;
    if ({obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall} !== 7'b0100111) begin
      errors++;
      $display("FAIL empty_status got %b want 0100111",
               {obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_gap_ok, obs_done_fall});
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if ({o_busy, o_bus_req} !== 2'b00) begin
        errors++; $display("FAIL ignored_start_queued c%0d got %b want 00", i, {o_busy, o_bus_req});
      end
    end
  endtask

  task automatic test_abort();
    i_mode_clk = 1; i_fmt_12h = 0; i_field_mask = 6'h3F;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    serve_seq(1, -1);
    checks++;
    if (obs_n !== 2) begin errors++; $display("FAIL abort_count got %0d want 2", obs_n); end
    checks++;
    if ({obs_a[0], obs_d[0], obs_a[1], obs_d[1]} !== 32'h2159_2230) begin
      errors++;
      $display("FAIL abort_pairs got %h want 21592230", {obs_a[0], obs_d[0], obs_a[1], obs_d[1]});
    end
    checks++;
    if ({obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_done_fall} !== 6'b011011) begin
      errors++;
      $display("FAIL abort_status got %b want 011011",
               {obs_timeout, obs_done, obs_abt, obs_busy_end, obs_drop_ok, obs_done_fall});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      checks++;
      if (o_bus_req !== 1'b0) begin
        errors++; $display("FAIL abort_no_xfer c%0d got %b want 0", i, o_bus_req);
      end
    end
  endtask

  task automatic test_reset_mid_cfg();
    i_mode_clk = 0; i_fmt_12h = 1; i_field_mask = 6'h00;
    pulse_req(1, 0);
    serve_seq(-1, 1);
    checks++;
    if ({obs_n, obs_a[0], obs_d[0]} !== {32'd1, 8'hF2, 8'h01}) begin
      errors++; $display("FAIL rst_xfer got n=%0d (%h,%h) want n=1 (f2,01)", obs_n, obs_a[0], obs_d[0]);
    end
    checks++;
    if (obs_pre !== 8'h18) begin
      errors++; $display("FAIL rst_cfg_data got %h want 18", obs_pre);
    end
    checks++;
    if (obs_rst !== 12'h000) begin
      errors++; $display("FAIL rst_outputs got %h want 000", obs_rst);
    end
    checks++;
    if (obs_rst_done !== 1'b0) begin
      errors++; $display("FAIL rst_no_done got %b want 0", obs_rst_done);
    end
  endtask

  task automatic test_snapshot();
    i_mode_clk = 1; i_fmt_12h = 0; i_field_mask = 6'h03;
    i_field_addr = ADDRS; i_field_data = DATAS;
    pulse_req(1, 0);
    i_field_data = {6{8'hFF}}; i_field_addr = '0; i_field_mask = 6'h3F;
    i_mode_clk = 0; i_fmt_12h = 1;
    serve_seq(-1, -1);
    checks++;
    if (obs_n !== 4) begin errors++; $display("FAIL snap_count got %0d want 4", obs_n); end
    checks++;
    if ({obs_a[0], obs_d[0], obs_a[1], obs_d[1], obs_a[2], obs_d[2], obs_a[3], obs_d[3]}
        !== 64'h2159_2230_F101_0000) begin
      errors++;
      $display("FAIL snap_pairs got %h want 21592230f1010000",
               {obs_a[0], obs_d[0], obs_a[1], obs_d[1], obs_a[2], obs_d[2], obs_a[3], obs_d[3]});
    end
  endtask

  initial begin
    test_reset();
    test_clock_write();
    test_timer(1'b0);
    test_timer(1'b1);
    test_init();
    test_sparse_mask();
    test_back_to_back();
    test_abort();
    test_reset_mid_cfg();
    test_snapshot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
